// File: rtl/apb_pkg.sv
// APB address window decoded to the audioport control slave.
package apb_pkg;

    localparam logic [31:0] DUT_START_ADDRESS = 32'h8C00_0000;
    localparam logic [31:0] DUT_END_ADDRESS   = 32'h8C00_022C;

endpackage

// File: rtl/audioport_pkg.sv
// audioport shared constants: register offsets, command codes, sample width,
// and the offset-to-register decode helper.
package audioport_pkg;

    localparam int AUDIO_WIDTH    = 24;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int DSP_REGS_DEF   = 128;

    localparam logic [11:0] OFF_CMD        = 12'h000;
    localparam logic [11:0] OFF_STATUS     = 12'h004;
    localparam logic [11:0] OFF_LEVEL      = 12'h008;
    localparam logic [11:0] OFF_CFG        = 12'h00C;
    localparam logic [11:0] OFF_DSP_FIRST  = 12'h010;
    localparam logic [11:0] OFF_DSP_LAST   = 12'h20C;
    localparam logic [11:0] OFF_LEFT_FIFO  = 12'h210;
    localparam logic [11:0] OFF_RIGHT_FIFO = 12'h214;
    localparam logic [11:0] OFF_RSVD_FIRST = 12'h218;
    localparam logic [11:0] OFF_RSVD_LAST  = 12'h22C;

    localparam logic [31:0] CMD_NOP    = 32'd0;
    localparam logic [31:0] CMD_CLR    = 32'd1;
    localparam logic [31:0] CMD_START  = 32'd2;
    localparam logic [31:0] CMD_STOP   = 32'd3;
    localparam logic [31:0] CMD_IRQACK = 32'd4;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CMD,
        SEL_STATUS,
        SEL_LEVEL,
        SEL_CFG,
        SEL_DSP,
        SEL_LEFT,
        SEL_RIGHT,
        SEL_RSVD
    } reg_sel_e;

    // Word-aligned, in-window offset to register target.
    function automatic reg_sel_e decode_offset(input logic [11:0] off);
        if (off == OFF_CMD)                                  return SEL_CMD;
        if (off == OFF_STATUS)                               return SEL_STATUS;
        if (off == OFF_LEVEL)                                return SEL_LEVEL;
        if (off == OFF_CFG)                                  return SEL_CFG;
        if (off >= OFF_DSP_FIRST && off <= OFF_DSP_LAST)     return SEL_DSP;
        if (off == OFF_LEFT_FIFO)                            return SEL_LEFT;
        if (off == OFF_RIGHT_FIFO)                           return SEL_RIGHT;
        if (off >= OFF_RSVD_FIRST && off <= OFF_RSVD_LAST)   return SEL_RSVD;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/audioport_fifo.sv
// Synchronous sample FIFO with show-ahead read data. clr dominates push/pop;
// a push to a full FIFO only lands when a pop frees a slot in the same cycle.
module audioport_fifo
    import audioport_pkg::*;
#(
    parameter int WIDTH = AUDIO_WIDTH,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]               count_q, count_d;
    logic                        do_push, do_pop;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/audioport_apb_ctrl.sv
// audioport APB control slave: register file, command decode, left/right
// sample FIFOs and the sample-request/underrun-interrupt path.
// Build option AUDIOPORT_PSLVERR_EN: report illegal accesses on pslverr_out;
// without it the same accesses are silently suppressed.
module audioport_apb_ctrl
    import apb_pkg::*;
    import audioport_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DSP_REGS   = DSP_REGS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        psel_in,
    input  logic                        penable_in,
    input  logic                        pwrite_in,
    input  logic [31:0]                 paddr_in,
    input  logic [31:0]                 pwdata_in,
    output logic [31:0]                 prdata_out,
    output logic                        pready_out,
    output logic                        pslverr_out,
    input  logic                        req_in,
    output logic [AUDIO_WIDTH-1:0]      audio0_out,
    output logic [AUDIO_WIDTH-1:0]      audio1_out,
    output logic                        play_out,
    output logic [31:0]                 cfg_out,
    output logic [31:0]                 level_out,
    output logic [DSP_REGS-1:0][31:0]   dsp_regs_out,
    output logic                        clr_out,
    output logic                        irq_out
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int DIW = $clog2(DSP_REGS);

    logic [31:0]              prdata_q, prdata_d;
    logic [AUDIO_WIDTH-1:0]   audio0_q, audio0_d, audio1_q, audio1_d;
    logic                     play_q, play_d, irq_q, irq_d, clr_q, clr_d;
    logic [31:0]              level_q, level_d, cfg_q, cfg_d;
    logic [DSP_REGS-1:0][31:0] dsp_q, dsp_d;

    logic                     addr_ok, wr_acc, rd_setup;
    reg_sel_e                 sel;
    logic [DIW-1:0]           dsp_idx;
    logic                     cmd_clr, cmd_start, cmd_stop, cmd_ack;
    logic                     l_push, r_push, pop, irq_set;
    logic [AUDIO_WIDTH-1:0]   l_rdata, r_rdata;
    logic [CW-1:0]            l_count, r_count;
    logic                     l_full, r_full, l_empty, r_empty;
    logic [31:0]              rd_mux;
    logic                     unused_ok;

    // Address decode, APB phase qualifiers, commands and FIFO controls.
    always_comb begin
        addr_ok   = (paddr_in >= DUT_START_ADDRESS) && (paddr_in <= DUT_END_ADDRESS)
                    && (paddr_in[1:0] == 2'b00);
        sel       = addr_ok ? decode_offset(paddr_in[11:0]) : SEL_NONE;
        dsp_idx   = DIW'((paddr_in[11:0] - OFF_DSP_FIRST) >> 2);
        wr_acc    = psel_in && penable_in && pwrite_in;
        rd_setup  = psel_in && !penable_in && !pwrite_in;
        cmd_clr   = wr_acc && (sel == SEL_CMD) && (pwdata_in == CMD_CLR);
        cmd_start = wr_acc && (sel == SEL_CMD) && (pwdata_in == CMD_START);
        cmd_stop  = wr_acc && (sel == SEL_CMD) && (pwdata_in == CMD_STOP);
        cmd_ack   = wr_acc && (sel == SEL_CMD) && (pwdata_in == CMD_IRQACK);
        // CLR takes priority over a coincident sample request.
        pop       = req_in && play_q && !cmd_clr;
        l_push    = wr_acc && (sel == SEL_LEFT) && (!l_full || pop);
        r_push    = wr_acc && (sel == SEL_RIGHT) && (!r_full || pop);
        // Left FIFO ends up empty after this pop (a push at count<=1 always lands).
        irq_set   = pop && (l_count <= CW'(1)) && !l_push;
    end

    // Read-data mux, sampled during the setup phase.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_STATUS: begin
                rd_mux[0]      = play_q;
                rd_mux[1]      = irq_q;
                rd_mux[8 +: CW] = l_count;
            end
            SEL_LEVEL: rd_mux = level_q;
            SEL_CFG:   rd_mux = cfg_q;
            SEL_DSP:   rd_mux = dsp_q[dsp_idx];
            default:   rd_mux = '0;
        endcase
    end

    // Register-file, play/irq and audio-output next state.
    always_comb begin
        prdata_d = prdata_q;
        audio0_d = audio0_q;
        audio1_d = audio1_q;
        play_d   = play_q;
        irq_d    = irq_q;
        clr_d    = cmd_clr;
        level_d  = level_q;
        cfg_d    = cfg_q;
        dsp_d    = dsp_q;
        if (rd_setup) begin
            prdata_d = rd_mux;
        end
        if (wr_acc) begin
            case (sel)
                SEL_LEVEL: level_d = pwdata_in;
                SEL_CFG:   cfg_d   = pwdata_in;
                SEL_DSP:   dsp_d[dsp_idx] = pwdata_in;
                default:   ;
            endcase
        end
        if (cmd_start) begin
            play_d = 1'b1;
        end
        if (cmd_stop) begin
            play_d = 1'b0;
        end
        if (cmd_stop || cmd_ack || cmd_clr) begin
            irq_d = 1'b0;
        end
        if (irq_set) begin
            irq_d = 1'b1;
        end
        if (cmd_clr) begin
            audio0_d = '0;
            audio1_d = '0;
        end else if (pop) begin
            audio0_d = l_empty ? '0 : l_rdata;
            audio1_d = r_empty ? '0 : r_rdata;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata_q <= '0;
            audio0_q <= '0;
            audio1_q <= '0;
            play_q   <= 1'b0;
            irq_q    <= 1'b0;
            clr_q    <= 1'b0;
            level_q  <= '0;
            cfg_q    <= '0;
            dsp_q    <= '0;
        end else begin
            prdata_q <= prdata_d;
            audio0_q <= audio0_d;
            audio1_q <= audio1_d;
            play_q   <= play_d;
            irq_q    <= irq_d;
            clr_q    <= clr_d;
            level_q  <= level_d;
            cfg_q    <= cfg_d;
            dsp_q    <= dsp_d;
        end
    end

    audioport_fifo #(.WIDTH(AUDIO_WIDTH), .DEPTH(FIFO_DEPTH)) u_left_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (l_push),
        .pop   (pop),
        .clr   (cmd_clr),
        .wdata (pwdata_in[AUDIO_WIDTH-1:0]),
        .rdata (l_rdata),
        .count (l_count),
        .full  (l_full),
        .empty (l_empty)
    );

    audioport_fifo #(.WIDTH(AUDIO_WIDTH), .DEPTH(FIFO_DEPTH)) u_right_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (r_push),
        .pop   (pop),
        .clr   (cmd_clr),
        .wdata (pwdata_in[AUDIO_WIDTH-1:0]),
        .rdata (r_rdata),
        .count (r_count),
        .full  (r_full),
        .empty (r_empty)
    );

`ifdef AUDIOPORT_PSLVERR_EN
    logic err;

    // Illegal access-phase transfers: bad write targets, dropped FIFO pushes,
    // unknown commands, and reads of write-only ports.
    always_comb begin
        err = 1'b0;
        if (psel_in && penable_in) begin
            if (pwrite_in) begin
                err = (sel == SEL_STATUS) || (sel == SEL_RSVD)
                      || ((sel == SEL_LEFT) && l_full && !pop)
                      || ((sel == SEL_RIGHT) && r_full && !pop)
                      || ((sel == SEL_CMD) && (pwdata_in > CMD_IRQACK));
            end else begin
                err = (sel == SEL_CMD) || (sel == SEL_LEFT) || (sel == SEL_RIGHT);
            end
        end
    end

    assign pslverr_out = err;
`else
    assign pslverr_out = 1'b0;
`endif

    // Right-channel occupancy is not reported anywhere.
    assign unused_ok    = ^r_count;

    assign prdata_out   = prdata_q;
    assign pready_out   = 1'b1;
    assign audio0_out   = audio0_q;
    assign audio1_out   = audio1_q;
    assign play_out     = play_q;
    assign cfg_out      = cfg_q;
    assign level_out    = level_q;
    assign dsp_regs_out = dsp_q;
    assign clr_out      = clr_q;
    assign irq_out      = irq_q;

endmodule
